// File: rtl/simd_pipe_core_if.sv
`default_nettype none
// ============================================================================
// Module   : simd_pipe_core_if
// Brief    : Issue-side and writeback-side handshake/data bundle for simd_pipe_core.
// Revision : 1.0
// ============================================================================
interface simd_pipe_core_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              opcode;
    logic                    sat;
    logic [LANES-1:0]        lane_mask;
    logic signed [WIDTH-1:0] A [LANES];
    logic signed [WIDTH-1:0] B [LANES];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] R [LANES];
    logic [LANES-1:0]        ovf;
    logic                    err;

    modport master (
        output in_valid, opcode, sat, lane_mask, A, B, out_ready,
        input  in_ready, out_valid, R, ovf, err
    );

    modport slave (
        input  in_valid, opcode, sat, lane_mask, A, B, out_ready,
        output in_ready, out_valid, R, ovf, err
    );
endinterface
`default_nettype wire

// File: rtl/simd_pipe_core.sv
`default_nettype none
// ============================================================================
// Module   : simd_pipe_core
// Brief    : Two-stage SIMD ALU; S1 forms raw lane results, S2 applies
//            saturation, lane masking and illegal-opcode handling.
// Revision : 1.0
// ============================================================================
module simd_pipe_core #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    simd_pipe_core_if.slave bus
);
    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_MUL = 4'b0100;
    localparam logic [3:0] c_OP_XOR = 4'b0101;
    localparam logic [3:0] c_OP_MIN = 4'b0110;
    localparam logic [3:0] c_OP_MAX = 4'b0111;
    localparam logic [3:0] c_OP_SHL = 4'b1000;
    localparam logic [3:0] c_OP_SRA = 4'b1001;

    localparam logic signed [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_advance;
    logic w_in_ready;
    logic w_accept;

    // Stage-1 combinational lane results
    logic signed [WIDTH:0]     w_a1      [LANES];
    logic signed [WIDTH:0]     w_b1      [LANES];
    logic signed [2*WIDTH-1:0] w_a_ext   [LANES];
    logic signed [2*WIDTH-1:0] w_b_ext   [LANES];
    logic signed [WIDTH:0]     w_sum     [LANES];
    logic signed [2*WIDTH-1:0] w_prod    [LANES];
    logic signed [WIDTH-1:0]   w_misc    [LANES];
    logic [LANES-1:0]          w_raw_ovf;

    logic                      r_s1_valid;
    logic [3:0]                r_s1_op;
    logic                      r_s1_sat;
    logic [LANES-1:0]          r_s1_mask;
    logic signed [WIDTH-1:0]   r_s1_a       [LANES];
    logic signed [WIDTH:0]     r_s1_sum     [LANES];
    logic signed [WIDTH-1:0]   r_s1_prod_lo [LANES];
    logic [LANES-1:0]          r_s1_prod_neg;
    logic signed [WIDTH-1:0]   r_s1_misc    [LANES];
    logic [LANES-1:0]          r_s1_ovf;

    logic signed [WIDTH-1:0]   w_r [LANES];
    logic [LANES-1:0]          w_ovf;
    logic                      w_err;

    logic                      r_out_valid;
    logic signed [WIDTH-1:0]   r_r [LANES];
    logic [LANES-1:0]          r_ovf;
    logic                      r_err;

    assign w_advance     = !r_out_valid || bus.out_ready;
    assign w_in_ready    = !r_s1_valid || w_advance;
    assign w_accept      = bus.in_valid && w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.R         = r_r;
    assign bus.ovf       = r_ovf;
    assign bus.err       = r_err;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_a1[i]    = {bus.A[i][WIDTH-1], bus.A[i]};
            w_b1[i]    = {bus.B[i][WIDTH-1], bus.B[i]};
            w_a_ext[i] = {{WIDTH{bus.A[i][WIDTH-1]}}, bus.A[i]};
            w_b_ext[i] = {{WIDTH{bus.B[i][WIDTH-1]}}, bus.B[i]};
            w_sum[i]   = (bus.opcode == c_OP_SUB) ? (w_a1[i] - w_b1[i]) : (w_a1[i] + w_b1[i]);
            w_prod[i]  = w_a_ext[i] * w_b_ext[i];

            w_misc[i] = '0;
            case (bus.opcode)
                c_OP_AND: w_misc[i] = bus.A[i] & bus.B[i];
                c_OP_OR:  w_misc[i] = bus.A[i] | bus.B[i];
                c_OP_XOR: w_misc[i] = bus.A[i] ^ bus.B[i];
                c_OP_MIN: w_misc[i] = (bus.A[i] < bus.B[i]) ? bus.A[i] : bus.B[i];
                c_OP_MAX: w_misc[i] = (bus.A[i] > bus.B[i]) ? bus.A[i] : bus.B[i];
                c_OP_SHL: w_misc[i] = bus.A[i] << bus.B[i][SHW-1:0];
                c_OP_SRA: w_misc[i] = bus.A[i] >>> bus.B[i][SHW-1:0];
                default:  w_misc[i] = '0;
            endcase

            // A product fits only if its top WIDTH+1 bits are a pure sign extension
            w_raw_ovf[i] = 1'b0;
            case (bus.opcode)
                c_OP_ADD, c_OP_SUB: w_raw_ovf[i] = w_sum[i][WIDTH] ^ w_sum[i][WIDTH-1];
                c_OP_MUL: w_raw_ovf[i] = (w_prod[i][2*WIDTH-1:WIDTH-1] != '0) &&
                                         (w_prod[i][2*WIDTH-1:WIDTH-1] != '1);
                default:  w_raw_ovf[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_op       <= '0;
            r_s1_sat      <= 1'b0;
            r_s1_mask     <= '0;
            r_s1_ovf      <= '0;
            r_s1_prod_neg <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_a[i]       <= '0;
                r_s1_sum[i]     <= '0;
                r_s1_prod_lo[i] <= '0;
                r_s1_misc[i]    <= '0;
            end
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_accept) begin
                r_s1_op   <= bus.opcode;
                r_s1_sat  <= bus.sat;
                r_s1_mask <= bus.lane_mask;
                r_s1_ovf  <= w_raw_ovf;
                for (int i = 0; i < LANES; i++) begin
                    r_s1_a[i]        <= bus.A[i];
                    r_s1_sum[i]      <= w_sum[i];
                    r_s1_prod_lo[i]  <= w_prod[i][WIDTH-1:0];
                    r_s1_prod_neg[i] <= w_prod[i][2*WIDTH-1];
                    r_s1_misc[i]     <= w_misc[i];
                end
            end
        end
    end

    // Illegal opcodes zero every lane and override the mask
    always_comb begin
        w_err = (r_s1_op > c_OP_SRA);
        w_ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            w_r[i] = '0;
            if (!w_err) begin
                if (!r_s1_mask[i]) begin
                    w_r[i] = r_s1_a[i];
                end else begin
                    w_ovf[i] = r_s1_ovf[i];
                    case (r_s1_op)
                        c_OP_ADD, c_OP_SUB: begin
                            if (r_s1_sat && r_s1_ovf[i])
                                w_r[i] = r_s1_sum[i][WIDTH] ? c_SAT_MIN : c_SAT_MAX;
                            else
                                w_r[i] = r_s1_sum[i][WIDTH-1:0];
                        end
                        c_OP_MUL: begin
                            if (r_s1_sat && r_s1_ovf[i])
                                w_r[i] = r_s1_prod_neg[i] ? c_SAT_MIN : c_SAT_MAX;
                            else
                                w_r[i] = r_s1_prod_lo[i];
                        end
                        default: w_r[i] = r_s1_misc[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ovf       <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_r[i] <= '0;
            end
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_ovf <= w_ovf;
                r_err <= w_err;
                for (int i = 0; i < LANES; i++) begin
                    r_r[i] <= w_r[i];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/simd_pipe_core.md
# simd_pipe_core

Pipelined, parametrised successor to the single-cycle SIMD ALU. It executes one vector instruction per cycle across `LANES` signed lanes and has:
- a two-stage pipeline with a valid/ready handshake on both sides;
- per-lane write masking;
- an optional saturating mode with per-lane overflow flags;
- an extended opcode set, including min/max and shifts.

It sits between the vector issue logic and the vector register-file writeback.

## Interface
- WIDTH, 32, lane width in bits (≥8).
- LANES, 4, number of lanes (≥1).
- SHW, $clog2(WIDTH), shift-amount width (derived).
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  core accepts instruction this cycle.
- opcode  in  4  operation select.
- sat  in  1  1 = saturate ADD/SUB/MUL.
- lane_mask  in  LANES  1 = lane active.
- A  in  signed WIDTH × [0:LANES-1]  operand A.
- B  in  signed WIDTH × [0:LANES-1]  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- R  out  signed WIDTH × [0:LANES-1]  result.
- ovf  out  LANES  per-lane signed overflow.
- err  out  1  illegal opcode for this result.

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 MUL (signed, low WIDTH bits)
  - 0101 XOR
  - 0110 MIN (signed)
  - 0111 MAX (signed)
  - 1000 SHL by B[i][SHW-1:0]
  - 1001 SRA by B[i][SHW-1:0]
- Opcodes 1010–1111 are illegal.
- Stage 1 (S1):
  - Captures opcode, sat, mask and A.
  - Computes per lane a (WIDTH+1)-bit sum/difference, a 2·WIDTH-bit product, the logic/compare/shift result, and the raw overflow bit.
- Stage 2 (S2):
  - Applies saturation, masking and error handling, then registers R/ovf/err.
- Overflow:
  - ADD/SUB: the true result lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - MUL: the full product is not representable in WIDTH bits.
  - All other ops: ovf=0.
- Overflow is reported whether or not sat is set.
- sat=1 with ovf=1 on a lane: R[i] = 2^(WIDTH−1)−1 if the true result is positive, else −2^(WIDTH−1). With sat=0, R[i] is the wrapped low WIDTH bits.
- Masked lane (lane_mask[i]=0): R[i]=A[i], ovf[i]=0.
- Illegal opcode: every R[i]=0, ovf=0, err=1, regardless of the mask. The instruction still flows through the pipeline and must be consumed like any other.
- Handshake:
  - An instruction is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - advance = !out_valid || out_ready.
  - in_ready = !s1_valid || advance.
  - No instruction is dropped or duplicated; order is preserved.
- Stall: while out_valid && !out_ready, R/ovf/err/out_valid hold stable and S1 holds. in_ready drops only when S1 is full and the output is stalled.

## Timing
- Reset (asynchronous, immediate):
  - s1_valid=0, out_valid=0, all R=0, ovf=0, err=0.
  - in_ready=1 from the first cycle after reset deassertion.
- Reset mid-operation discards both in-flight instructions; no result from before reset appears afterwards.
- Latency: an instruction accepted at edge N gives out_valid=1 after edge N+1 (two registers), assuming no stall.
- Throughput is one instruction per cycle with out_ready held high.
- Simultaneous accept and consume with both stages full: S2 loads from S1 and S1 loads the new instruction in the same edge.
- S1 empty while S2 is consumed: out_valid falls the next cycle; no bubble-fill with stale data.
- Input values (in_valid, opcode, sat, lane_mask, A, B) are sampled only at an accept edge. Changing them while in_ready=0 has no effect.

## Test plan
- Reset, then ADD with WIDTH=32, mask=1111, out_ready=1: A=(1,−5,7fffffff,80000000), B=(2,5,1,ffffffff), sat=0 → after 2 cycles R=(3,0,80000000,7fffffff), ovf=1100, err=0.
- Same operands with sat=1 → R=(3,0,7fffffff,80000000), ovf=1100.
- MUL, sat=1: A0=0x10000, B0=0x10000 → R0=7fffffff, ovf[0]=1. A1=−3, B1=4 → R1=−12, ovf[1]=0. With mask=0101, lanes 1 and 3 return A1/A3 with ovf 0.
- Back-to-back stream of 8 mixed ops (MIN, MAX, SHL by 31, SRA of 80000000 by 4 → f8000000) with out_ready held low for cycles 3–6:
  - in_ready falls exactly when both stages are full.
  - Outputs hold stable during the stall.
  - All 8 results arrive in order, with no loss or duplication.
- Opcode 1011 → R all 0, err=1, ovf=0. The next legal op following it returns err=0.
- Assert rst while 2 instructions are in flight → outputs clear immediately. After release, out_valid stays 0 until a new instruction has been accepted and 2 cycles have elapsed.
